// File: rtl/rbm_ctrl_pkg.sv
// Shared definitions for the RBM iteration sequencer: state encodings,
// saturation limits and the saturating adder used by every accumulator lane.
// Latency: n/a (types and pure functions only). Backpressure: n/a.
package rbm_ctrl_pkg;

  // 2-bit state encodings
  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_CLEAR = 2'd1;
  localparam logic [1:0] ENC_RUN   = 2'd2;
  localparam logic [1:0] ENC_DONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ENC_IDLE,
    ST_CLEAR = ENC_CLEAR,
    ST_RUN   = ENC_RUN,
    ST_DONE  = ENC_DONE
  } state_t;

  // Limits for the default 12-bit datapath; the clamp is symmetric so the
  // most-negative two's complement code never appears.
  localparam int DEF_BITLENGTH = 12;
  localparam int SAT_MAX = (1 << (DEF_BITLENGTH - 1)) - 1;
  localparam int SAT_MIN = -SAT_MAX;

  // Full-precision add of two sign-extended operands, clamped to
  // +/-(2^(bl-1)-1). Operands must already fit in bl bits (bl <= 31).
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int bl);
    logic signed [32:0] s;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    s  = {a[31], a} + {b[31], b};
    hi = (33'sd1 <<< (bl - 1)) - 33'sd1;
    lo = -hi;
    if (s > hi) begin
      return 32'(hi);
    end else if (s < lo) begin
      return 32'(lo);
    end
    return 32'(s);
  endfunction

endpackage

// File: rtl/rbm_iteration_sequencer_if.sv
// Handshake bundle between the sequencer, its sample source, the layer chain
// and the result consumer. Latency: n/a (wires only). Backpressure: carried by
// in_valid/in_ready and out_valid/out_ready.
// master = sequencer side; slave = sample source / layer chain / consumer side.
interface rbm_iteration_sequencer_if #(
  parameter int BITLENGTH  = 12,
  parameter int OUTPUT_DIM = 2,
  parameter int ITER_W     = 16,
  parameter int CLS_W      = $clog2(OUTPUT_DIM)
);
  logic                             in_valid;
  logic                             in_ready;
  logic [ITER_W-1:0]                iter_cfg;
  logic                             layer_clear;
  logic                             layer_start;
  logic                             layer_done;
  logic [OUTPUT_DIM*BITLENGTH-1:0]  layer_out;
  logic                             out_valid;
  logic                             out_ready;
  logic [OUTPUT_DIM*BITLENGTH-1:0]  vote_sum;
  logic [CLS_W-1:0]                 class_idx;
  logic [ITER_W-1:0]                iter_count;
  logic                             timeout_err;
  logic                             busy;

  modport master (
    input  in_valid, iter_cfg, layer_done, layer_out, out_ready,
    output in_ready, layer_clear, layer_start, out_valid, vote_sum,
           class_idx, iter_count, timeout_err, busy
  );

  modport slave (
    output in_valid, iter_cfg, layer_done, layer_out, out_ready,
    input  in_ready, layer_clear, layer_start, out_valid, vote_sum,
           class_idx, iter_count, timeout_err, busy
  );
endinterface

// File: rtl/rbm_sat_accumulator.sv
// One signed accumulator lane with synchronous clear, enable and symmetric saturation.
// Latency: 1 cycle from en/add_in to acc. Backpressure: none, en qualifies each add.
// Ports: clock, reset (async high), clear, en, add_in (signed), acc (signed).
module rbm_sat_accumulator
  import rbm_ctrl_pkg::*;
#(
  parameter int BITLENGTH = 12
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        en,
  input  logic signed [BITLENGTH-1:0] add_in,
  output logic signed [BITLENGTH-1:0] acc
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= BITLENGTH'(sat_add(32'(acc), 32'(add_in), BITLENGTH));
    end
  end

endmodule

// File: rtl/rbm_iteration_sequencer.sv
// Runs the RBM layer chain for N Gibbs iterations per sample and sums class outputs.
// Latency: out_valid in cycle 1+N*(1+L) after accept (L = RUN cycles per iteration).
// Backpressure: holds DONE with stable results until out_ready; in_ready only in IDLE.
// Ports: clock, reset (async high), bus (master modport: sample handshake,
// layer chain control/results, result handshake with vote_sum/class_idx).
module rbm_iteration_sequencer
  import rbm_ctrl_pkg::*;
#(
  parameter int BITLENGTH      = 12,
  parameter int OUTPUT_DIM     = 2,
  parameter int ITERATION_NUM  = 100,
  parameter int ITER_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CLS_W          = $clog2(OUTPUT_DIM)
) (
  input  logic clock,
  input  logic reset,
  rbm_iteration_sequencer_if.master bus
);

  // Sized so TIMEOUT_CYCLES-1 always fits, even for tiny timeouts.
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t              state;
  logic [ITER_W-1:0]   target;
  logic [ITER_W-1:0]   iter_cnt;
  logic [WD_W-1:0]     wd;
  logic                tmo;

  logic                accept;
  logic                acc_en;
  logic signed [BITLENGTH-1:0] acc_q [OUTPUT_DIM];

  assign accept = (state == ST_IDLE) && bus.in_valid;
  // Only a done pulse seen in RUN contributes to the sums.
  assign acc_en = (state == ST_RUN) && bus.layer_done;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      target   <= '0;
      iter_cnt <= '0;
      wd       <= '0;
      tmo      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            target   <= (bus.iter_cfg == '0) ? ITER_W'(ITERATION_NUM) : bus.iter_cfg;
            iter_cnt <= '0;
            tmo      <= 1'b0;
            state    <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          wd    <= '0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          // A done pulse takes priority over the watchdog firing in the same cycle.
          if (bus.layer_done) begin
            iter_cnt <= iter_cnt + ITER_W'(1);
            if ((iter_cnt + ITER_W'(1)) == target) begin
              state <= ST_DONE;
            end else begin
              state <= ST_CLEAR;
            end
          end else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
            tmo   <= 1'b1;
            state <= ST_DONE;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < OUTPUT_DIM; i++) begin : g_acc
    rbm_sat_accumulator #(.BITLENGTH(BITLENGTH)) u_acc (
      .clock  (clock),
      .reset  (reset),
      .clear  (accept),
      .en     (acc_en),
      .add_in (bus.layer_out[i*BITLENGTH +: BITLENGTH]),
      .acc    (acc_q[i])
    );
    assign bus.vote_sum[i*BITLENGTH +: BITLENGTH] = acc_q[i];
  end

  // Strictly-greater scan: on ties the lowest index is kept.
  always_comb begin
    logic signed [BITLENGTH-1:0] best_v;
    bus.class_idx = '0;
    best_v        = acc_q[0];
    for (int i = 1; i < OUTPUT_DIM; i++) begin
      if (acc_q[i] > best_v) begin
        best_v        = acc_q[i];
        bus.class_idx = CLS_W'(i);
      end
    end
  end

  assign bus.in_ready    = (state == ST_IDLE) && !reset;
  assign bus.layer_clear = (state == ST_CLEAR);
  assign bus.layer_start = (state == ST_RUN);
  assign bus.out_valid   = (state == ST_DONE);
  assign bus.busy        = (state != ST_IDLE);
  assign bus.iter_count  = iter_cnt;
  assign bus.timeout_err = tmo;

endmodule
